// File: rtl/rotary_paddle_decoder_if.sv
// Paddle decoder bus: raw encoder pins and frame strobe in, frame-stable paddle state out.
// The master drives the pins and the frame tick; the slave is the decoder itself.
interface rotary_paddle_decoder_if;
  logic       rota;
  logic       rotb;
  logic       frame_tick;
  logic [9:0] paddle_y;
  logic       moved;
  logic       dir;

  modport master (
    output rota,
    output rotb,
    output frame_tick,
    input  paddle_y,
    input  moved,
    input  dir
  );

  modport slave (
    input  rota,
    input  rotb,
    input  frame_tick,
    output paddle_y,
    output moved,
    output dir
  );
endinterface

// File: rtl/rotary_paddle_decoder.sv
// Rotary encoder to paddle position: synchronize, debounce, quadrature decode, saturating
// accumulate, and publish the result only on frame boundaries so the paddle never tears.

// Invariant watcher: the published paddle stays in range and moved only follows a frame tick.
module rotary_paddle_decoder_chk #(
  parameter logic [9:0] PADDLE_MIN = 10'd0,
  parameter logic [9:0] PADDLE_MAX = 10'd416
) (
  input logic       Clock,
  input logic       Reset,
  input logic       frame_tick,
  input logic       moved,
  input logic [9:0] paddle_y
);
  logic [10:0] offset_s;
  logic [10:0] span_s;

  assign offset_s = {1'b0, paddle_y} - {1'b0, PADDLE_MIN};
  assign span_s   = {1'b0, PADDLE_MAX} - {1'b0, PADDLE_MIN};

  a_paddle_in_range : assert property (
    @(posedge Clock) disable iff (Reset) offset_s <= span_s
  );

  a_moved_after_tick : assert property (
    @(posedge Clock) disable iff (Reset) moved |-> $past(frame_tick)
  );
endmodule

module rotary_paddle_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter logic [9:0]  STEP            = 10'd8,
  parameter logic [9:0]  PADDLE_MIN      = 10'd0,
  parameter logic [9:0]  PADDLE_MAX      = 10'd416,
  parameter logic [9:0]  RESET_POS       = 10'd208
) (
  input logic                    Clock,
  input logic                    Reset,
  rotary_paddle_decoder_if.slave bus
);
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Returns {next stable level, next counter}: a level is accepted only after it has
  // differed from the stable value for DEBOUNCE_CYCLES consecutive clocks.
  function automatic logic [CNT_W:0] debounce_next(
    input logic             sync_v,
    input logic             stable_v,
    input logic [CNT_W-1:0] cnt_v
  );
    logic [CNT_W:0] res;
    if (sync_v != stable_v) begin
      if (cnt_v == CNT_LAST) begin
        res = {sync_v, {CNT_W{1'b0}}};
      end else begin
        res = {stable_v, cnt_v + CNT_W'(1)};
      end
    end else begin
      res = {stable_v, {CNT_W{1'b0}}};
    end
    return res;
  endfunction

  logic             a_meta_r;
  logic             a_sync_r;
  logic             b_meta_r;
  logic             b_sync_r;
  logic             a_stable_r;
  logic             b_stable_r;
  logic [CNT_W-1:0] a_cnt_r;
  logic [CNT_W-1:0] b_cnt_r;
  logic [1:0]       prev_r;
  logic [9:0]       pending_r;
  logic [9:0]       paddle_y_r;
  logic             moved_r;
  logic             dir_r;

  logic [CNT_W:0]   a_deb_s;
  logic [CNT_W:0]   b_deb_s;
  logic [1:0]       pair_s;
  logic [10:0]      inc_sum_s;
  logic [10:0]      dec_floor_s;
  logic [9:0]       inc_val_s;
  logic [9:0]       dec_val_s;
  logic [9:0]       pending_nxt_s;
  logic             dir_nxt_s;

  assign a_deb_s     = debounce_next(a_sync_r, a_stable_r, a_cnt_r);
  assign b_deb_s     = debounce_next(b_sync_r, b_stable_r, b_cnt_r);
  assign pair_s      = {a_stable_r, b_stable_r};
  assign inc_sum_s   = {1'b0, pending_r} + {1'b0, STEP};
  assign dec_floor_s = {1'b0, PADDLE_MIN} + {1'b0, STEP};

  // Saturating step candidates, computed one bit wider so neither direction can wrap.
  always_comb begin
    inc_val_s = inc_sum_s[9:0];
    dec_val_s = pending_r - STEP;
    if (inc_sum_s > {1'b0, PADDLE_MAX}) begin
      inc_val_s = PADDLE_MAX;
    end else begin
      inc_val_s = inc_sum_s[9:0];
    end
    if ({1'b0, pending_r} < dec_floor_s) begin
      dec_val_s = PADDLE_MIN;
    end else begin
      dec_val_s = pending_r - STEP;
    end
  end

  // Quadrature decode: only entries into 00 count; every other change just moves prev.
  always_comb begin
    pending_nxt_s = pending_r;
    dir_nxt_s     = dir_r;
    case ({prev_r, pair_s})
      4'b10_00: begin
        pending_nxt_s = inc_val_s;
        dir_nxt_s     = 1'b1;
      end
      4'b01_00: begin
        pending_nxt_s = dec_val_s;
        dir_nxt_s     = 1'b0;
      end
      default: begin
        pending_nxt_s = pending_r;
        dir_nxt_s     = dir_r;
      end
    endcase
  end

  // Pin synchronizers and per-phase debouncers; rest state of the encoder is 11.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_meta_r   <= 1'b1;
      a_sync_r   <= 1'b1;
      b_meta_r   <= 1'b1;
      b_sync_r   <= 1'b1;
      a_stable_r <= 1'b1;
      b_stable_r <= 1'b1;
      a_cnt_r    <= {CNT_W{1'b0}};
      b_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      a_meta_r   <= bus.rota;
      a_sync_r   <= a_meta_r;
      b_meta_r   <= bus.rotb;
      b_sync_r   <= b_meta_r;
      a_stable_r <= a_deb_s[CNT_W];
      b_stable_r <= b_deb_s[CNT_W];
      a_cnt_r    <= a_deb_s[CNT_W-1:0];
      b_cnt_r    <= b_deb_s[CNT_W-1:0];
    end
  end

  // Step accumulation plus frame latch; a step landing on a tick shows at the next tick.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      prev_r     <= 2'b11;
      pending_r  <= RESET_POS;
      dir_r      <= 1'b0;
      paddle_y_r <= RESET_POS;
      moved_r    <= 1'b0;
    end else begin
      prev_r    <= pair_s;
      pending_r <= pending_nxt_s;
      dir_r     <= dir_nxt_s;
      if (bus.frame_tick) begin
        paddle_y_r <= pending_r;
        moved_r    <= (pending_r != paddle_y_r);
      end else begin
        paddle_y_r <= paddle_y_r;
        moved_r    <= 1'b0;
      end
    end
  end

  assign bus.paddle_y = paddle_y_r;
  assign bus.moved    = moved_r;
  assign bus.dir      = dir_r;

  rotary_paddle_decoder_chk #(
    .PADDLE_MIN (PADDLE_MIN),
    .PADDLE_MAX (PADDLE_MAX)
  ) u_chk (
    .Clock      (Clock),
    .Reset      (Reset),
    .frame_tick (bus.frame_tick),
    .moved      (moved_r),
    .paddle_y   (paddle_y_r)
  );
endmodule

// File: tb/tb_rotary_paddle_decoder.sv
// Bench for rotary_paddle_decoder with a short debounce window; expected frame outputs are
// queued when a tick is driven and compared after the edge that latches them.
module tb_rotary_paddle_decoder;
  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  rotary_paddle_decoder_if bus ();

  rotary_paddle_decoder #(
    .DEBOUNCE_CYCLES (4),
    .STEP            (10'd8),
    .PADDLE_MIN      (10'd0),
    .PADDLE_MAX      (10'd416),
    .RESET_POS       (10'd208)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [9:0] y;
    logic       m;
    logic       d;
  } exp_t;

  typedef struct {
    string      name;
    bit         glitch;
    int         cw;
    int         ccw;
    logic [9:0] y;
    logic       m;
    logic       d;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic push_exp(input string name, input logic [9:0] y, input logic m, input logic d);
    exp_t e;
    e.name = name;
    e.y    = y;
    e.m    = m;
    e.d    = d;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: DUT output sampled with no expectation queued");
    end else begin
      e = sb_q.pop_front();
      if (bus.paddle_y !== e.y || bus.moved !== e.m || bus.dir !== e.d) begin
        failures++;
        $display("FAIL %s: got paddle_y=%0d moved=%b dir=%b, want paddle_y=%0d moved=%b dir=%b",
                 e.name, bus.paddle_y, bus.moved, bus.dir, e.y, e.m, e.d);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clock);
      bus.frame_tick = 1'b0;
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    @(negedge Clock);
    bus.rota       = a;
    bus.rotb       = b;
    bus.frame_tick = 1'b0;
    @(posedge Clock);
    #1;
    idle(n - 1);
  endtask

  task automatic tick_check(input string name, input logic t, input logic [9:0] y,
                            input logic m, input logic d);
    @(negedge Clock);
    bus.frame_tick = t;
    push_exp(name, y, m, d);
    @(posedge Clock);
    #1;
    check_out();
  endtask

  task automatic frame(input string name, input logic [9:0] y, input logic m, input logic d);
    tick_check(name, 1'b1, y, m, d);
    tick_check({name, "_drop"}, 1'b0, y, 1'b0, d);
  endtask

  task automatic cw_detent();
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
  endtask

  task automatic ccw_detent();
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
  endtask

  // From 10, a short dip of A into 00 would be a CW step if it were accepted.
  task automatic glitch_a();
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
  endtask

  task automatic reset_dut();
    @(negedge Clock);
    Reset          = 1'b1;
    bus.rota       = 1'b1;
    bus.rotb       = 1'b1;
    bus.frame_tick = 1'b0;
    idle(3);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"glitch_a",     1'b1, 0,  0,  10'd208, 1'b0, 1'b0};
    vecs[1] = '{"cw1",          1'b0, 1,  0,  10'd216, 1'b1, 1'b1};
    vecs[2] = '{"cw2_ccw1",     1'b0, 2,  1,  10'd224, 1'b1, 1'b0};
    vecs[3] = '{"ccw30_sat",    1'b0, 0,  30, 10'd0,   1'b1, 1'b0};
    vecs[4] = '{"ccw_at_min",   1'b0, 0,  1,  10'd0,   1'b0, 1'b0};
    vecs[5] = '{"cw60_sat",     1'b0, 60, 0,  10'd416, 1'b1, 1'b1};
    vecs[6] = '{"cw_at_max",    1'b0, 1,  0,  10'd416, 1'b0, 1'b1};
    vecs[7] = '{"ccw_from_max", 1'b0, 0,  1,  10'd408, 1'b1, 1'b0};

    Reset          = 1'b1;
    bus.rota       = 1'b1;
    bus.rotb       = 1'b1;
    bus.frame_tick = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    push_exp("reset_state", 10'd208, 1'b0, 1'b0);
    check_out();

    for (int i = 0; i < 3; i++) begin
      idle(99);
      frame("idle_tick", 10'd208, 1'b0, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].glitch) glitch_a();
      repeat (vecs[i].cw) cw_detent();
      repeat (vecs[i].ccw) ccw_detent();
      idle(5);
      frame(vecs[i].name, vecs[i].y, vecs[i].m, vecs[i].d);
    end

    // Pin edge into 00 is edge k; pending must change on edge k+6, colliding with the tick.
    reset_dut();
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 1);
    idle(5);
    tick_check("step_on_tick", 1'b1, 10'd208, 1'b0, 1'b1);
    tick_check("tick_after_step", 1'b1, 10'd216, 1'b1, 1'b1);
    tick_check("tick_after_step_drop", 1'b0, 10'd216, 1'b0, 1'b1);
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);

    cw_detent();
    idle(5);
    frame("pre_reset", 10'd224, 1'b1, 1'b1);
    hold(1'b1, 1'b0, 10);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    push_exp("reset_mid_detent", 10'd208, 1'b0, 1'b0);
    check_out();
    idle(2);
    @(negedge Clock);
    Reset    = 1'b0;
    bus.rota = 1'b0;
    bus.rotb = 1'b0;
    @(posedge Clock);
    #1;
    idle(20);
    frame("post_reset_complete", 10'd208, 1'b0, 1'b0);
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    frame("post_reset_return", 10'd208, 1'b0, 1'b0);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d queued entries, want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
